// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, ROM drive, redirect squash, stall skid.
// Optional taken-redirect counter enabled by defining REDIRECT_COUNT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic        fd_valid,
    output logic [31:0] fd_pc,
    output logic [31:0] fd_ir,
    output logic        flush_dx,
    output logic [15:0] redirect_count
);

    logic [31:0] r_pc;
    logic        r_pend_valid;
    logic [31:0] r_pend_pc;
    logic        r_skid_valid;
    logic [31:0] r_skid_pc;
    logic [31:0] r_skid_ir;
    logic        r_fd_valid;
    logic [31:0] r_fd_pc;
    logic [31:0] r_fd_ir;

    logic [31:0] w_pc_nxt;
    logic        w_pend_valid_nxt;
    logic [31:0] w_pend_pc_nxt;
    logic        w_skid_valid_nxt;
    logic [31:0] w_skid_pc_nxt;
    logic [31:0] w_skid_ir_nxt;
    logic        w_fd_valid_nxt;
    logic [31:0] w_fd_pc_nxt;
    logic [31:0] w_fd_ir_nxt;

    logic        w_mode_redirect;
    logic        w_mode_stall;
    logic        w_mode_run;
    logic [31:0] w_pc_inc;

    assign w_mode_redirect = redirect_valid;
    assign w_mode_stall    = !redirect_valid && stall;
    assign w_mode_run      = !redirect_valid && !stall;

    // Word-addressed increment, wraps silently at 2^32.
    assign w_pc_inc  = r_pc + 32'd1;

    // The target is fetched in the redirect cycle itself to keep the penalty at one bubble.
    assign imem_addr = redirect_valid ? redirect_pc : r_pc;
    assign flush_dx  = redirect_valid;

    assign fd_valid  = r_fd_valid;
    assign fd_pc     = r_fd_pc;
    assign fd_ir     = r_fd_ir;

    // Next-state selection: redirect beats stall beats run.
    always_comb begin
        w_pc_nxt         = r_pc;
        w_pend_valid_nxt = r_pend_valid;
        w_pend_pc_nxt    = r_pend_pc;
        w_skid_valid_nxt = r_skid_valid;
        w_skid_pc_nxt    = r_skid_pc;
        w_skid_ir_nxt    = r_skid_ir;
        w_fd_valid_nxt   = r_fd_valid;
        w_fd_pc_nxt      = r_fd_pc;
        w_fd_ir_nxt      = r_fd_ir;
        unique case (1'b1)
            w_mode_redirect: begin
                w_pc_nxt         = redirect_pc + 32'd1;
                w_pend_valid_nxt = 1'b1;
                w_pend_pc_nxt    = redirect_pc;
                w_skid_valid_nxt = 1'b0;
                w_fd_valid_nxt   = 1'b0;
                w_fd_ir_nxt      = 32'd0;
            end
            w_mode_stall: begin
                w_pend_valid_nxt = 1'b0;
                if (r_pend_valid) begin
                    w_skid_valid_nxt = 1'b1;
                    w_skid_pc_nxt    = r_pend_pc;
                    w_skid_ir_nxt    = imem_rdata;
                end
            end
            w_mode_run: begin
                w_pc_nxt         = w_pc_inc;
                w_pend_valid_nxt = 1'b1;
                w_pend_pc_nxt    = r_pc;
                if (r_skid_valid) begin
                    w_skid_valid_nxt = 1'b0;
                    w_fd_valid_nxt   = 1'b1;
                    w_fd_pc_nxt      = r_skid_pc;
                    w_fd_ir_nxt      = r_skid_ir;
                end else if (r_pend_valid) begin
                    w_fd_valid_nxt   = 1'b1;
                    w_fd_pc_nxt      = r_pend_pc;
                    w_fd_ir_nxt      = imem_rdata;
                end else begin
                    w_fd_valid_nxt   = 1'b0;
                    w_fd_ir_nxt      = 32'd0;
                end
            end
            default: begin
                w_pc_nxt = r_pc;
            end
        endcase
    end

    // Fetch state registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pc         <= RESET_PC;
            r_pend_valid <= 1'b0;
            r_pend_pc    <= 32'd0;
            r_skid_valid <= 1'b0;
            r_skid_pc    <= 32'd0;
            r_skid_ir    <= 32'd0;
            r_fd_valid   <= 1'b0;
            r_fd_pc      <= 32'd0;
            r_fd_ir      <= 32'd0;
        end else begin
            r_pc         <= w_pc_nxt;
            r_pend_valid <= w_pend_valid_nxt;
            r_pend_pc    <= w_pend_pc_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
            r_skid_ir    <= w_skid_ir_nxt;
            r_fd_valid   <= w_fd_valid_nxt;
            r_fd_pc      <= w_fd_pc_nxt;
            r_fd_ir      <= w_fd_ir_nxt;
        end
    end

`ifdef REDIRECT_COUNT_EN
    logic [15:0] r_redirect_count;

    // Saturating count of taken redirects, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_redirect_count <= 16'd0;
        end else if (redirect_valid && (r_redirect_count != 16'hFFFF)) begin
            r_redirect_count <= r_redirect_count + 16'd1;
        end
    end

    assign redirect_count = r_redirect_count;
`else
    assign redirect_count = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table plus reset and counter sequences.
module tb_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        fd_valid;
    logic [31:0] fd_pc;
    logic [31:0] fd_ir;
    logic        flush_dx;
    logic [15:0] redirect_count;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        st;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] eir;
        logic [31:0] eaddr;
        logic        eflush;
    } vec_t;

    vec_t vecs[$];

    fetch_unit #(.RESET_PC(32'd0)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .fd_valid       (fd_valid),
        .fd_pc          (fd_pc),
        .fd_ir          (fd_ir),
        .flush_dx       (flush_dx),
        .redirect_count (redirect_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous ROM: word i holds i+100.
    always @(posedge clock) imem_rdata <= imem_addr + 32'd100;

    task automatic chk(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic add(input logic rv, input logic [31:0] rpc, input logic st,
                       input logic ev, input logic [31:0] epc,
                       input logic [31:0] eaddr, input logic eflush);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.st = st;
        v.ev = ev; v.epc = epc;
        v.eir = ev ? epc + 32'd100 : 32'd0;
        v.eaddr = eaddr; v.eflush = eflush;
        vecs.push_back(v);
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        stall = 1'b0;
        reset_n = 1'b0;

        // rv rpc st | ev epc addr flush  (inputs applied in that cycle)
        add(0, 0, 0,  0, 32'd0, 32'd0, 0);            // 0
        add(0, 0, 0,  0, 32'd0, 32'd1, 0);            // 1
        add(0, 0, 0,  1, 32'd0, 32'd2, 0);            // 2
        add(0, 0, 0,  1, 32'd1, 32'd3, 0);            // 3
        add(0, 0, 0,  1, 32'd2, 32'd4, 0);            // 4
        add(0, 0, 0,  1, 32'd3, 32'd5, 0);            // 5
        add(0, 0, 0,  1, 32'd4, 32'd6, 0);            // 6
        add(1, 40, 0, 1, 32'd5, 32'd40, 1);           // 7 redirect at pc=7
        add(0, 0, 0,  0, 32'd5, 32'd41, 0);           // 8 bubble
        add(0, 0, 0,  1, 32'd40, 32'd42, 0);          // 9
        add(0, 0, 0,  1, 32'd41, 32'd43, 0);          // 10
        add(0, 0, 1,  1, 32'd42, 32'd44, 0);          // 11 stall x3
        add(0, 0, 1,  1, 32'd42, 32'd44, 0);          // 12
        add(0, 0, 1,  1, 32'd42, 32'd44, 0);          // 13
        add(0, 0, 0,  1, 32'd42, 32'd44, 0);          // 14 release
        add(0, 0, 0,  1, 32'd43, 32'd45, 0);          // 15 from skid
        add(0, 0, 1,  1, 32'd44, 32'd46, 0);          // 16 stall fills skid
        add(1, 20, 1, 1, 32'd44, 32'd20, 1);          // 17 stall+redirect
        add(0, 0, 0,  0, 32'd44, 32'd21, 0);          // 18 bubble
        add(0, 0, 0,  1, 32'd20, 32'd22, 0);          // 19 skid dropped
        add(1, 32'hFFFF_FFFE, 0, 1, 32'd21, 32'hFFFF_FFFE, 1); // 20
        add(0, 0, 0,  0, 32'd21, 32'hFFFF_FFFF, 0);   // 21
        add(0, 0, 0,  1, 32'hFFFF_FFFE, 32'd0, 0);    // 22 wrap
        add(0, 0, 0,  1, 32'hFFFF_FFFF, 32'd1, 0);    // 23
        add(0, 0, 0,  1, 32'd0, 32'd2, 0);            // 24

        // Reset state while held in reset.
        repeat (3) @(posedge clock);
        #1;
        chk("rst_fd_valid", -1, {31'd0, fd_valid}, 32'd0);
        chk("rst_fd_pc", -1, fd_pc, 32'd0);
        chk("rst_fd_ir", -1, fd_ir, 32'd0);
        chk("rst_imem_addr", -1, imem_addr, 32'd0);
        chk("rst_count", -1, {16'd0, redirect_count}, 32'd0);

        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            redirect_valid = vecs[i].rv;
            redirect_pc = vecs[i].rpc;
            stall = vecs[i].st;
            #1;
            chk("fd_valid", i, {31'd0, fd_valid}, {31'd0, vecs[i].ev});
            chk("fd_pc", i, fd_pc, vecs[i].epc);
            chk("fd_ir", i, fd_ir, vecs[i].eir);
            chk("imem_addr", i, imem_addr, vecs[i].eaddr);
            chk("flush_dx", i, {31'd0, flush_dx}, {31'd0, vecs[i].eflush});
            @(posedge clock);
            #1;
        end
        redirect_valid = 1'b0;
        stall = 1'b0;
        #1;
`ifdef REDIRECT_COUNT_EN
        chk("count_after_3", -1, {16'd0, redirect_count}, 32'd3);
`else
        chk("count_after_3", -1, {16'd0, redirect_count}, 32'd0);
`endif

        // Asynchronous reset in the middle of a stall with skid full.
        stall = 1'b1;
        repeat (2) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        chk("midrst_fd_valid", -1, {31'd0, fd_valid}, 32'd0);
        chk("midrst_fd_pc", -1, fd_pc, 32'd0);
        chk("midrst_imem_addr", -1, imem_addr, 32'd0);
        chk("midrst_count", -1, {16'd0, redirect_count}, 32'd0);
        stall = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("restart_e1_valid", -1, {31'd0, fd_valid}, 32'd0);
        @(posedge clock);
        #1;
        chk("restart_e2_valid", -1, {31'd0, fd_valid}, 32'd1);
        chk("restart_e2_pc", -1, fd_pc, 32'd0);
        chk("restart_e2_ir", -1, fd_ir, 32'd100);

        // Continuous redirects: counter saturates when enabled.
        redirect_valid = 1'b1;
        redirect_pc = 32'd300;
`ifdef REDIRECT_COUNT_EN
        repeat (65537) @(posedge clock);
        #1;
        chk("count_sat", -1, {16'd0, redirect_count}, 32'h0000_FFFF);
`else
        repeat (10) @(posedge clock);
        #1;
        chk("count_off", -1, {16'd0, redirect_count}, 32'd0);
`endif
        chk("redirect_bubble", -1, {31'd0, fd_valid}, 32'd0);
        redirect_valid = 1'b0;
        @(posedge clock);
        #1;
        chk("redirect_tgt_pc", -1, fd_pc, 32'd300);
        chk("redirect_tgt_ir", -1, fd_ir, 32'd400);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that consumes the execute-stage branch/jump resolution (next PC plus taken flag) and produces the F/D latch contents. Owns the PC register, drives the synchronous instruction ROM, squashes wrong-path fetches on redirect, and holds the decode stage on a hazard stall via a one-entry skid buffer. Sits between the hazard unit, instruction memory and the D stage of the 5-stage pipeline.

## Interface
Parameters:
- RESET_PC, 32'd0, PC value loaded on reset.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- redirect_valid  input  1  execute stage took a branch/jump this cycle.
- redirect_pc  input  32  target PC, valid when redirect_valid=1.
- stall  input  1  hazard unit holds the F/D latch this cycle.
- imem_addr  output  32  word address to ROM; combinational: redirect_valid ? redirect_pc : pc.
- imem_rdata  input  32  ROM data; value in cycle t+1 belongs to imem_addr sampled at edge ending cycle t.
- fd_valid  output  1  F/D latch holds a real instruction.
- fd_pc  output  32  PC of instruction in F/D.
- fd_ir  output  32  instruction in F/D; 32'd0 (nop) whenever fd_valid=0.
- flush_dx  output  1  combinational copy of redirect_valid; D/X inserts a bubble.
- redirect_count  output  16  taken-redirect counter (see Configuration).

## Operation
- State: pc[31:0], pend_valid/pend_pc (ROM response in flight), skid_valid/skid_pc/skid_ir, F/D latch.
- PC arithmetic: word-addressed, pc+1, modulo 2^32 (0xFFFFFFFF wraps to 0, no flag).
- Effective mode per cycle, priority order: REDIRECT > STALL > RUN.
- REDIRECT (redirect_valid=1, stall ignored): pc<=redirect_pc+1; pend_valid<=1, pend_pc<=redirect_pc; skid_valid<=0; fd_valid<=0, fd_ir<=0. Arriving imem_rdata discarded.
- STALL: pc, F/D latch held; pend_valid<=0. If pend_valid=1 this cycle, arriving data captured: skid<= {1, pend_pc, imem_rdata}. Otherwise skid held.
- RUN, skid_valid=1: F/D<= skid; skid_valid<=0; pc<=pc+1; pend_valid<=1, pend_pc<=pc. Arriving data ignored (pend_valid is 0 here by construction).
- RUN, skid_valid=0: F/D<= pend_valid ? {1, pend_pc, imem_rdata} : {0, fd_pc, 0}; pc<=pc+1; pend_valid<=1, pend_pc<=pc.
- Skid can never be written while full: capture requires pend_valid=1, which requires a preceding RUN cycle, which drains skid.

## Timing
- Reset (async assert, sync to edge on release): pc=RESET_PC, pend_valid=0, skid_valid=0, fd_valid=0, fd_pc=0, fd_ir=0, redirect_count=0; imem_addr=RESET_PC, flush_dx follows input.
- Startup: first edge after release issues RESET_PC; fd_valid=1 with fd_pc=RESET_PC after second edge.
- Redirect penalty: exactly one bubble cycle in F/D; target instruction in F/D after second edge following the redirect cycle.
- Stall release: held-in-flight instruction appears in F/D at the first RUN edge; no instruction lost or duplicated.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately; skid contents lost.

## Configuration
- REDIRECT_COUNT_EN defined: redirect_count increments by 1 at each edge with redirect_valid=1, saturates at 16'hFFFF, cleared only by reset.
- Not defined: counter logic absent, redirect_count tied to 16'd0.

## Test plan
- Reset, ROM[i]=i+100, no stall/redirect -> fd_pc 0,1,2,3 on consecutive cycles starting 2nd edge after release, fd_ir=fd_pc+100.
- Redirect_valid=1, redirect_pc=40 at cycle with pc=7 -> imem_addr=40 that cycle, flush_dx=1, next cycle fd_valid=0/fd_ir=0, following cycle fd_pc=40 then 41.
- Stall 3 cycles while fd_pc=5 -> fd holds 5 for 3 cycles, then fd_pc 6,7,8 consecutively, no gaps/duplicates.
- Stall and redirect same cycle (target 20) -> redirect wins, skid cleared, fd_pc=20 two edges later.
- pc=32'hFFFFFFFF, RUN -> next fetch address 0, fd_pc sequence FFFFFFFF, 0.
- With REDIRECT_COUNT_EN: 3 redirects -> redirect_count=3; force 65537 redirects -> 16'hFFFF; without macro -> always 0.
